// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle controller.
// Holds the state encodings, the datapath select codes,
// the data-processing cmd codes and the ARM condition codes.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMRD    = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWR    = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_UNKNOWN  = 4'd10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_AND) || (cmd == CMD_ORR);
  endfunction

endpackage

// File: rtl/mc_controller_cond_unit.sv
// cond_unit: NZCV flag register, registered condition result and
// flag-write gating for the multicycle controller.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   cond         instruction condition field
//   alu_flags    {N,Z,C,V} from the ALU in the current cycle
//   cond_load    capture the condition result (end of DECODE)
//   flag_req     instruction asks to set flags (EXECUTE with S = 1)
//   flag_all     arithmetic op: write C,V as well as N,Z
//   cond_ok      condition result held for the rest of the instruction
//   flags        current {N,Z,C,V}
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_load,
  input  logic       flag_req,
  input  logic       flag_all,
  output logic       cond_ok,
  output logic [3:0] flags
);

  logic n, z, c, v;
  logic cond_ex;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // 1111 never executes
    endcase
  end

  // Flags update uses the cond_ok captured in DECODE, so a failed
  // instruction leaves NZCV untouched even though it walks EXECUTE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags   <= 4'b0000;
      cond_ok <= 1'b0;
    end else begin
      if (cond_load) cond_ok <= cond_ex;
      if (flag_req && cond_ok) begin
        flags[3:2] <= alu_flags[3:2];
        if (flag_all) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: main FSM and ALU decoder for the multicycle
// ARM-subset datapath; drives every enable and mux select.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   Instr             instruction bits [31:12]
//   ALUFlags          {N,Z,C,V} from the ALU
//   PCWrite .. RegWrite  datapath controls (Moore, per state)
//   ImmSrc, RegSrc    decoded straight from Instr in every state
//   state_o           current state encoding
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC + 4
// DECODE   | register read, condition captured
// MEMADR   | address = Rn + imm
// MEMRD    | memory read at ALU result
// MEMWB    | load data to Rd
// MEMWR    | store Rd to memory
// EXECUTER | ALU op, register operand
// EXECUTEI | ALU op, immediate operand
// ALUWB    | ALU result to Rd
// BRANCH   | PC <= PC + 8 + imm
// UNKNOWN  | unsupported opcode, no writes
module mc_controller
  import mc_pkg::*;
#(
  parameter logic UNKNOWN_HANG = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  state_o
);

  state_t     state, state_nx;
  logic [1:0] op;
  logic [3:0] cmd, rd, cond;
  logic       i_bit, s_bit, cond_ok;
  logic [1:0] alu_dec;
  logic       pc_raw, mem_raw, ir_raw, reg_raw;
  logic       unused_rn;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign i_bit = Instr[13];
  assign cmd   = Instr[12:9];
  assign s_bit = Instr[8];
  assign rd    = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00: begin
            if (!cmd_supported(cmd)) state_nx = S_UNKNOWN;
            else if (i_bit)          state_nx = S_EXECUTEI;
            else                     state_nx = S_EXECUTER;
          end
          2'b01:   state_nx = S_MEMADR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_nx = s_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nx = S_MEMWB;
      S_EXECUTER: state_nx = S_ALUWB;
      S_EXECUTEI: state_nx = S_ALUWB;
      S_UNKNOWN:  state_nx = UNKNOWN_HANG ? S_UNKNOWN : S_FETCH;
      default:    state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    case (cmd)
      CMD_SUB: alu_dec = ALU_SUB;
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    pc_raw     = 1'b0;
    mem_raw    = 1'b0;
    ir_raw     = 1'b0;
    reg_raw    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    case (state)
      S_FETCH: begin
        ir_raw    = 1'b1;
        pc_raw    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        // Writing R15 goes through the PC register, not the file.
        if (rd == 4'hF) pc_raw  = cond_ok;
        else            reg_raw = cond_ok;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        mem_raw = cond_ok;
      end
      S_EXECUTER: ALUControl = alu_dec;
      S_EXECUTEI: begin
        ALUControl = alu_dec;
        ALUSrcB    = SRCB_IMM;
      end
      S_ALUWB: begin
        if (rd == 4'hF) pc_raw  = cond_ok;
        else            reg_raw = cond_ok;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_raw    = cond_ok;
      end
      default: ;
    endcase
  end

  // Reset is asynchronous and FETCH asserts enables, so gate them
  // directly with reset to keep the datapath quiet while it is held.
  assign PCWrite  = pc_raw  & ~reset;
  assign MemWrite = mem_raw & ~reset;
  assign IRWrite  = ir_raw  & ~reset;
  assign RegWrite = reg_raw & ~reset;

  assign ImmSrc  = op;
  assign RegSrc  = {op == 2'b01, op == 2'b10};
  assign state_o = state;

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .cond_load (state == S_DECODE),
    .flag_req  (((state == S_EXECUTER) || (state == S_EXECUTEI)) && s_bit),
    .flag_all  ((cmd == CMD_ADD) || (cmd == CMD_SUB)),
    .cond_ok   (cond_ok),
    .flags     ()
  );

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;

  logic PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0] state_o;

  logic h_pcw, h_adr, h_mw, h_irw, h_srca, h_rw;
  logic [1:0] h_rs, h_alu, h_srcb, h_imm, h_regsrc;
  logic [3:0] h_state;

  mc_controller #(.UNKNOWN_HANG(1'b0)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite),
    .state_o(state_o)
  );

  mc_controller #(.UNKNOWN_HANG(1'b1)) dut_h (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(h_pcw), .AdrSrc(h_adr), .MemWrite(h_mw), .IRWrite(h_irw),
    .ResultSrc(h_rs), .ALUControl(h_alu), .ALUSrcA(h_srca),
    .ALUSrcB(h_srcb), .ImmSrc(h_imm), .RegSrc(h_regsrc), .RegWrite(h_rw),
    .state_o(h_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [3:0]  flg;
    logic [3:0]  hst;
    logic        hchk;
    string       tag;
  } rec_t;

  rec_t q[$];
  rec_t mr;
  int   n_vec = 0;
  int   n_err = 0;
  event sample_ev;
  logic [3:0] exp_flags = 4'h0;
  logic       hang_stuck = 1'b0;
  logic [15:0] ctl_act;
  logic        bad;

  localparam logic [19:0] SEQ_DPR = {4'd0, S_ALUWB, S_EXECUTER, S_DECODE, S_FETCH};
  localparam logic [19:0] SEQ_DPI = {4'd0, S_ALUWB, S_EXECUTEI, S_DECODE, S_FETCH};
  localparam logic [19:0] SEQ_LDR = {S_MEMWB, S_MEMRD, S_MEMADR, S_DECODE, S_FETCH};
  localparam logic [19:0] SEQ_STR = {4'd0, S_MEMWR, S_MEMADR, S_DECODE, S_FETCH};
  localparam logic [19:0] SEQ_B   = {8'd0, S_BRANCH, S_DECODE, S_FETCH};
  localparam logic [19:0] SEQ_UNK = {8'd0, S_UNKNOWN, S_DECODE, S_FETCH};

  // Reference control word {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,
  // ALUControl,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,RegWrite} from the state table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [19:0] ins,
                                           input logic ok, input logic rst);
    logic pcw, adr, mw, irw, srca, rw;
    logic [1:0] rs, alu, srcb, op;
    pcw = 0; adr = 0; mw = 0; irw = 0; srca = 0; rw = 0;
    rs = 2'b00; alu = 2'b00; srcb = 2'b00;
    op = ins[15:14];
    case (st)
      S_FETCH:  begin irw = 1; pcw = 1; srca = 1; srcb = 2'b10; rs = 2'b10; end
      S_DECODE: begin srca = 1; srcb = 2'b10; rs = 2'b10; end
      S_MEMADR: srcb = 2'b01;
      S_MEMRD:  adr = 1;
      S_MEMWB:  begin rs = 2'b01; if (ins[3:0] == 4'hF) pcw = ok; else rw = ok; end
      S_MEMWR:  begin adr = 1; mw = ok; end
      S_EXECUTER, S_EXECUTEI: begin
        srcb = (st == S_EXECUTEI) ? 2'b01 : 2'b00;
        case (ins[12:9])
          4'b0010: alu = 2'b01;
          4'b0000: alu = 2'b10;
          4'b1100: alu = 2'b11;
          default: alu = 2'b00;
        endcase
      end
      S_ALUWB:  begin if (ins[3:0] == 4'hF) pcw = ok; else rw = ok; end
      S_BRANCH: begin srcb = 2'b01; rs = 2'b10; pcw = ok; end
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rs, alu, srca, srcb, op, (op == 2'b01), (op == 2'b10), rw};
  endfunction

  task automatic push_recs(input logic [19:0] ins, input int n, input logic [19:0] seq,
                           input logic ok, input logic [3:0] nf, input string tag);
    rec_t r;
    for (int k = 0; k < n; k++) begin
      r.st   = seq[4*k +: 4];
      r.ctl  = exp_ctrl(r.st, ins, ok, 1'b0);
      r.flg  = (k >= 3) ? nf : exp_flags;
      r.hst  = hang_stuck ? S_UNKNOWN : r.st;
      r.hchk = hang_stuck;
      r.tag  = $sformatf("%s.c%0d", tag, k);
      q.push_back(r);
    end
  endtask

  task automatic run(input logic [19:0] ins, input logic [3:0] af, input int n,
                     input logic [19:0] seq, input logic ok, input logic [3:0] nf,
                     input string tag);
    Instr = ins;
    ALUFlags = af;
    push_recs(ins, n, seq, ok, nf, tag);
    repeat (n) @(negedge clk);
    exp_flags = nf;
  endtask

  task automatic push_reset_rec(input string tag);
    rec_t r;
    r.st   = S_FETCH;
    r.ctl  = exp_ctrl(S_FETCH, Instr, 1'b0, 1'b1);
    r.flg  = 4'h0;
    r.hst  = S_FETCH;
    r.hchk = 1'b1;
    r.tag  = tag;
    q.push_back(r);
  endtask

  initial forever begin
    @(negedge clk);
    #1 -> sample_ev;
  end

  initial forever begin
    @(sample_ev);
    if (q.size() > 0) begin
      mr = q.pop_front();
      n_vec++;
      bad = 1'b0;
      ctl_act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                 ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite};
      if (state_o !== mr.st) begin
        $display("FAIL %s state: got %0d want %0d", mr.tag, state_o, mr.st); bad = 1'b1;
      end
      if (ctl_act !== mr.ctl) begin
        $display("FAIL %s ctl: got %b want %b", mr.tag, ctl_act, mr.ctl); bad = 1'b1;
      end
      if (dut.u_cond.flags !== mr.flg) begin
        $display("FAIL %s flags: got %b want %b", mr.tag, dut.u_cond.flags, mr.flg); bad = 1'b1;
      end
      if (h_state !== mr.hst) begin
        $display("FAIL %s hang_state: got %0d want %0d", mr.tag, h_state, mr.hst); bad = 1'b1;
      end
      if (mr.hchk && ({h_pcw, h_irw, h_mw, h_rw} !== 4'b0000)) begin
        $display("FAIL %s hang_en: got %b want 0000", mr.tag, {h_pcw, h_irw, h_mw, h_rw});
        bad = 1'b1;
      end
      if (bad) n_err++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    push_reset_rec("reset");
    @(negedge clk);
    reset = 1'b0;

    run(20'hE0821, 4'b1111, 4, SEQ_DPR, 1'b1, 4'b0000, "add");
    run(20'hE5921, 4'b0000, 5, SEQ_LDR, 1'b1, 4'b0000, "ldr");
    run(20'hE5821, 4'b0000, 4, SEQ_STR, 1'b1, 4'b0000, "str");
    run(20'hE2500, 4'b0110, 4, SEQ_DPI, 1'b1, 4'b0110, "subs_z");
    run(20'h0A000, 4'b0000, 3, SEQ_B,   1'b1, 4'b0110, "beq_taken");
    run(20'hE2500, 4'b0000, 4, SEQ_DPI, 1'b1, 4'b0000, "subs_nz");
    run(20'h0A000, 4'b1111, 3, SEQ_B,   1'b0, 4'b0000, "beq_not");
    run(20'h00821, 4'b1111, 4, SEQ_DPR, 1'b0, 4'b0000, "addeq_fail");
    run(20'h00121, 4'b1111, 4, SEQ_DPR, 1'b0, 4'b0000, "andseq_fail");
    run(20'hE2500, 4'b0011, 4, SEQ_DPI, 1'b1, 4'b0011, "subs_cv");
    run(20'hE0121, 4'b1100, 4, SEQ_DPR, 1'b1, 4'b1111, "ands_keep_cv");
    run(20'hE182F, 4'b0000, 4, SEQ_DPR, 1'b1, 4'b1111, "orr_pc");
    run(20'hE0221, 4'b0000, 3, SEQ_UNK, 1'b1, 4'b1111, "eor_unknown");
    hang_stuck = 1'b1;
    run(20'hEC000, 4'b0000, 3, SEQ_UNK, 1'b1, 4'b1111, "op11");
    run(20'hE5921, 4'b0000, 5, SEQ_LDR, 1'b1, 4'b1111, "ldr_hang");

    // Store interrupted by reset in MEMWR.
    Instr = 20'hE5821;
    push_recs(20'hE5821, 4, SEQ_STR, 1'b1, exp_flags, "str_rst");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 push_reset_rec("rst_in_memwr");
    -> sample_ev;
    @(negedge clk);
    push_reset_rec("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    exp_flags = 4'h0;
    hang_stuck = 1'b0;

    run(20'hE0821, 4'b0000, 4, SEQ_DPR, 1'b1, 4'b0000, "add_after_rst");
    run(20'h05921, 4'b0000, 5, SEQ_LDR, 1'b0, 4'b0000, "ldreq_fail");
    run(20'h05821, 4'b0000, 4, SEQ_STR, 1'b0, 4'b0000, "streq_fail");

    @(negedge clk);
    #3;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle controller for the ARM-subset processor. It sequences a shared-memory multicycle datapath (single ALU, one memory, instruction register) through fetch, decode, execute, memory and writeback steps. It combines a main state machine, an ALU decoder, condition-code evaluation and the NZCV flag register. It sits beside the datapath and drives every enable and mux select on it.

Parameters:
UNKNOWN_HANG, 0, 1: the UNKNOWN state holds until reset; 0: UNKNOWN returns to FETCH after one cycle.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
Instr  input  20  instruction register bits [31:12]
ALUFlags  input  4  {N,Z,C,V} from the datapath ALU, current cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUControl  output  2  00 add, 01 sub, 10 and, 11 orr
ALUSrcA  output  1  0 register A, 1 PC
ALUSrcB  output  2  00 register B, 01 ExtImm, 10 constant 4
ImmSrc  output  2  extend select (equals Op)
RegSrc  output  2  [0]: Rn = R15 for branch; [1]: Rm = Rd for store
RegWrite  output  1  register file write enable
state_o  output  4  current state encoding, for the bench

Behaviour:
- Fields: Op = Instr[27:26], Funct = Instr[25:20] (I = Funct[5], cmd = Funct[4:1], S/L = Funct[0]), Rd = Instr[15:12], Cond = Instr[31:28].
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN. Encoding lives in the package.
- Reset: state = FETCH, flags = 0000, cond_ok = 0. While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op = 00, I = 0 -> EXECUTER; Op = 00, I = 1 -> EXECUTEI.
    - Op = 01 -> MEMADR.
    - Op = 10 -> BRANCH.
    - Op = 11, or Op = 00 with cmd not in {ADD 0100, SUB 0010, AND 0000, ORR 1100} -> UNKNOWN.
  - MEMADR: L = 1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH. MEMWR -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH. BRANCH -> FETCH.
  - UNKNOWN -> FETCH, or holds if UNKNOWN_HANG = 1.
- Moore outputs per state (all unlisted enables 0, unlisted selects 0):
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 1, ALUSrcB 10, ALU add, ResultSrc 10, PCWrite 1 (PC + 4).
  - DECODE: ALUSrcA 1, ALUSrcB 10, add, ResultSrc 10. Reads PC + 8 for R15.
  - MEMADR: ALUSrcA 0, ALUSrcB 01, add.
  - MEMRD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite = cond_ok.
  - MEMWR: AdrSrc 1, MemWrite = cond_ok.
  - EXECUTER: ALUSrcB 00, ALUControl from cmd. EXECUTEI: same, with ALUSrcB 01.
  - ALUWB: ResultSrc 00, RegWrite = cond_ok.
  - BRANCH: ALUSrcA 0, ALUSrcB 01, add, ResultSrc 10, PCWrite = cond_ok.
  - UNKNOWN: all enables 0.
- Writes to R15: in MEMWB or ALUWB with Rd = 15, PCWrite = cond_ok and RegWrite = 0.
- Combinational from Instr in every state: ImmSrc = Op, RegSrc[0] = (Op == 10), RegSrc[1] = (Op == 01).
- Condition check:
  - CondEx is evaluated from Cond against the flag register, standard ARM table 0000–1110.
  - Cond = 1111 evaluates false.
  - cond_ok is registered at the end of DECODE only and holds for the rest of the instruction.
- Flag update:
  - Happens only at the end of EXECUTER/EXECUTEI, and only if cond_ok and S = 1.
  - ADD/SUB write all of NZCV; AND/ORR write N,Z only, C,V are kept.
- Boundaries:
  - A failed condition still walks every state, so timing is fixed; only writes are suppressed.
  - Flags written by instruction k are visible to the DECODE of instruction k+1.
  - Reset mid-instruction aborts immediately to FETCH, with no partial write after release.
- Latency in cycles: data-processing 4, LDR 5, STR 4, B 3, UNKNOWN 3.

Decomposition:
- Package mc_pkg: state enum, ALUControl / ResultSrc / ALUSrcB localparams, cmd codes, condition codes.
- One sub-module, cond_unit: flag register, cond_ok register, condition table, flag-write gating.
- FSM and ALU decode stay in mc_controller.

Test Plan:
- ADD R1,R2,R3 (Instr[31:12] = 0xE0821):
  - states FETCH, DECODE, EXECUTER, ALUWB.
  - ALUControl = 00 in EXECUTER; RegWrite = 1 only in ALUWB; flags unchanged.
- LDR R1,[R2,#4] (0xE5921): 5 cycles; AdrSrc = 1 in MEMRD; ResultSrc = 01 and RegWrite = 1 in MEMWB. STR (0xE5821): MemWrite = 1 only in MEMWR, RegSrc = 10.
- SUBS R0,R0,#1 (0xE2500) with ALUFlags = 0110 in EXECUTEI -> flags = 0110. Then BEQ (0x0A000) -> PCWrite = 1 in BRANCH. Repeat with ALUFlags = 0000 -> BRANCH PCWrite = 0, cycle count still 3.
- Condition fail: flags Z = 0, ADDEQ (0x00821) -> RegWrite = 0 in ALUWB. ANDS with cond fail -> flags unchanged.
- Op = 11 (0xEC000) -> UNKNOWN, with zero enables. UNKNOWN_HANG = 0 returns to FETCH; UNKNOWN_HANG = 1 stays in UNKNOWN for 10 cycles.
- Assert reset during MEMWR -> MemWrite drops the same cycle, state_o = FETCH, flags = 0000. After release, first cycle is FETCH with IRWrite = 1.
